// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: round-robin accept, registered execute,
// then the tagged result is held until the consumer acknowledges it.
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [2:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             res_id,
  output logic             res_valid,
  input  logic             res_ack,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             prio;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic             accept;
  logic             winner;
  logic [WIDTH-1:0] alu_out;

  // With both requests up the pointer decides; otherwise the lone requester wins.
  always_comb begin
    accept = (state == IDLE) && (req0 || req1);
    winner = (req0 && req1) ? prio : req1;
    gnt0   = accept && !winner;
    gnt1   = accept && winner;
  end

  // NOTE: every output of a combinational block gets a default before the case,
  // so no path through it can leave a value unassigned and infer a latch.
  always_comb begin
    alu_out = '0;
    case (op_q)
      3'd0: alu_out = a_q + b_q;
      3'd1: alu_out = a_q - b_q;
      3'd2: alu_out = a_q ^ b_q;
      3'd3: alu_out = a_q & b_q;
      3'd4: alu_out = a_q | b_q;
      3'd5: alu_out = a_q + {{(WIDTH-1){1'b0}}, 1'b1};
      3'd6: alu_out = a_q << 1;
      3'd7: alu_out = a_q >> 1;
      default: alu_out = '0;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      res_id    <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= winner ? op1 : op0;
            a_q   <= winner ? a1 : a0;
            b_q   <= winner ? b1 : b0;
            id_q  <= winner;
            prio  <= ~winner;
            state <= EXEC;
          end
        end
        EXEC: begin
          result    <= alu_out;
          zero      <= (alu_out == '0);
          res_id    <= id_q;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ack) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
